// File: rtl/alu_sequencer.sv
// Program sequencer for an external accumulator ALU: buffers {opcode, B} entries,
// replays them one per cycle from a seed, and reports the final result or the faulting entry.
module alu_sequencer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_opcode,
    input  logic [WIDTH-1:0] wr_operand,
    output logic             wr_ready,
    input  logic             prog_clr,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic             alu_rst,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_status,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       err_index,
    output logic [3:0]       count
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op_mem [DEPTH];
    logic [WIDTH-1:0] r_b_mem  [DEPTH];
    logic [3:0]       r_count;
    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_error;
    logic [2:0]       r_err_index;

    logic             w_room;
    logic             w_last;
    logic             w_abort;
    logic             w_mem_we;
    logic [AW-1:0]    w_wr_addr;

    assign w_room    = (r_count < DEPTH_C);
    assign w_last    = ((4'(r_idx) + 4'd1) == r_count);
    // Status in the first ISSUE cycle belongs to no instruction yet, so it is masked.
    assign w_abort   = (r_state == S_ISSUE) && (r_idx != {AW{1'b0}}) && alu_status;
    assign w_mem_we  = (r_state == S_IDLE) && !start && wr_en && (prog_clr || w_room);
    assign w_wr_addr = prog_clr ? {AW{1'b0}} : r_count[AW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (r_count != 4'd0)) begin
                    w_next = S_CLEAR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CLEAR: w_next = S_ISSUE;
            S_ISSUE: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DRAIN;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_DRAIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Program buffer storage; contents survive runs and resets, only count is cleared.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_op_mem[w_wr_addr] <= wr_opcode;
            r_b_mem[w_wr_addr]  <= wr_operand;
        end
    end

    // Entry count, run index and result/status capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 4'd0;
            r_idx       <= {AW{1'b0}};
            r_seed      <= {WIDTH{1'b0}};
            r_result    <= {WIDTH{1'b0}};
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        if (r_count != 4'd0) begin
                            r_seed <= seed;
                            r_idx  <= {AW{1'b0}};
                        end else begin
                            r_result <= seed;
                            r_done   <= 1'b1;
                        end
                    end else if (prog_clr) begin
                        r_count <= wr_en ? 4'd1 : 4'd0;
                    end else if (wr_en && w_room) begin
                        r_count <= r_count + 4'd1;
                    end else begin
                        r_count <= r_count;
                    end
                end
                S_CLEAR: r_idx <= {AW{1'b0}};
                S_ISSUE: begin
                    if (w_abort) begin
                        r_result    <= alu_out;
                        r_err_index <= 3'(r_idx - AW'(1));
                        r_error     <= 1'b1;
                        r_done      <= 1'b1;
                    end else if (!w_last) begin
                        r_idx <= r_idx + AW'(1);
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                S_DRAIN: begin
                    if (alu_status) begin
                        r_error     <= 1'b1;
                        r_err_index <= 3'(r_count - 4'd1);
                    end
                    r_result <= alu_out;
                    r_done   <= 1'b1;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    // ALU drive; an aborting cycle zeroes the op so the next entry never reaches the ALU.
    always_comb begin
        alu_rst    = 1'b1;
        alu_A      = {WIDTH{1'b0}};
        alu_B      = {WIDTH{1'b0}};
        alu_opcode = 3'd0;
        case (r_state)
            S_IDLE:  alu_rst = 1'b1;
            S_CLEAR: alu_A   = r_seed;
            S_ISSUE: begin
                alu_rst = 1'b0;
                alu_A   = r_seed;
                if (!w_abort) begin
                    alu_opcode = r_op_mem[r_idx];
                    alu_B      = r_b_mem[r_idx];
                end else begin
                    alu_opcode = 3'd0;
                    alu_B      = {WIDTH{1'b0}};
                end
            end
            S_DRAIN: alu_rst = 1'b0;
            default: alu_rst = 1'b1;
        endcase
    end

    assign wr_ready  = (r_state == S_IDLE) && w_room;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign error     = r_error;
    assign result    = r_result;
    assign err_index = r_err_index;
    assign count     = r_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural accumulator ALU plus a scoreboard of expected run outcomes.
module tb_alu_sequencer;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd5;

    logic        clk = 1'b0;
    logic        rst, wr_en, prog_clr, start;
    logic [2:0]  wr_opcode;
    logic [15:0] wr_operand, seed;
    logic        wr_ready, alu_rst, alu_status, busy, done, error;
    logic [15:0] alu_A, alu_B, alu_out, result;
    logic [2:0]  alu_opcode, err_index;
    logic [3:0]  count;

    alu_sequencer #(.DEPTH(8), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_opcode(wr_opcode), .wr_operand(wr_operand),
        .wr_ready(wr_ready), .prog_clr(prog_clr), .start(start), .seed(seed),
        .alu_rst(alu_rst), .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_status(alu_status), .busy(busy), .done(done),
        .error(error), .result(result), .err_index(err_index), .count(count)
    );

    always #5 clk = ~clk;

    // Reference ALU: bit 16 is carry (ADD) or borrow (SUB), which drives status.
    function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [15:0] alu_acc;
    logic        alu_first, alu_st;
    logic [16:0] alu_nxt;
    assign alu_nxt    = alu_f(alu_opcode, alu_first ? alu_A : alu_acc, alu_B);
    assign alu_out    = alu_acc;
    assign alu_status = alu_st;

    always @(posedge clk) begin
        if (alu_rst) begin
            alu_acc <= 16'h0000; alu_first <= 1'b1; alu_st <= 1'b0;
        end else if (alu_opcode != 3'd0) begin
            alu_acc <= alu_nxt[15:0]; alu_st <= alu_nxt[16]; alu_first <= 1'b0;
        end else begin
            alu_st <= 1'b0;
        end
    end

    typedef struct packed {
        logic [15:0] res;
        logic        err;
        logic [2:0]  eidx;
        logic [7:0]  lat;
        logic [7:0]  ops;
        logic        zero;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [2:0]  m_op[$];
    logic [15:0] m_b[$];
    logic [2:0]  last_eidx = 3'd0;
    int n_vec = 0, n_bad = 0;
    int cyc = 0, start_cyc = 0, n_done = 0, done_base = 0;
    int ops_total = 0, ops_base = 0, busy_total = 0, busy_base = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts issued ops / busy cycles and pops the scoreboard on every done.
    always @(posedge clk) begin
        #2;
        if (!alu_rst && alu_opcode != 3'd0) ops_total++;
        if (busy) busy_total++;
        if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("error", 32'(error), 32'(mon_e.err));
                chk("err_index", 32'(err_index), 32'(mon_e.eidx));
                chk("latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
                chk("alu_ops", 32'(ops_total - ops_base), 32'(mon_e.ops));
                if (mon_e.zero) chk("busy_cycles", 32'(busy_total - busy_base), 32'd0);
            end
        end
    end

    task automatic load(input logic [2:0] op, input logic [15:0] b);
        wr_en = 1'b1; wr_opcode = op; wr_operand = b;
        @(negedge clk);
        wr_en = 1'b0;
        if (m_op.size() < 8) begin
            m_op.push_back(op); m_b.push_back(b);
        end
    endtask

    task automatic clear_prog(input logic with_wr, input logic [2:0] op, input logic [15:0] b);
        prog_clr = 1'b1; wr_en = with_wr; wr_opcode = op; wr_operand = b;
        @(negedge clk);
        prog_clr = 1'b0; wr_en = 1'b0;
        m_op.delete(); m_b.delete();
        if (with_wr) begin
            m_op.push_back(op); m_b.push_back(b);
        end
    endtask

    task automatic run_start(input logic [15:0] seed_v, input logic with_wr);
        exp_t        e;
        logic [15:0] acc;
        logic [16:0] r;
        int          n;
        n = m_op.size();
        acc = seed_v;
        e.err = 1'b0; e.eidx = last_eidx; e.zero = (n == 0);
        e.lat = 8'(n + 3); e.ops = 8'(n);
        if (n == 0) begin
            e.lat = 8'd1; e.ops = 8'd0;
        end
        for (int i = 0; i < n; i++) begin
            r = alu_f(m_op[i], acc, m_b[i]);
            acc = r[15:0];
            if (r[16]) begin
                e.err = 1'b1; e.eidx = 3'(i); e.lat = 8'(4 + i); e.ops = 8'(i + 1);
                break;
            end
        end
        e.res = acc;
        last_eidx = e.eidx;
        sb_q.push_back(e);
        ops_base = ops_total; busy_base = busy_total; start_cyc = cyc; done_base = n_done;
        start = 1'b1; seed = seed_v; wr_en = with_wr; wr_opcode = OP_ADD; wr_operand = 16'h7777;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic run_wait();
        for (int i = 0; i < 64 && n_done == done_base; i++) @(negedge clk);
        if (n_done == done_base) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; prog_clr = 1'b0; start = 1'b0;
        wr_opcode = 3'd0; wr_operand = 16'h0000; seed = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err_index", 32'(err_index), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alu_rst", 32'(alu_rst), 32'd1);
        chk("rst_alu_drv", {alu_A, alu_B} | 32'(alu_opcode), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_wr_ready", 32'(wr_ready), 32'd1);

        // Two ADDs from seed 5, then re-run the retained program with another seed.
        load(OP_ADD, 16'd3); load(OP_ADD, 16'd4);
        chk("count_two", 32'(count), 32'd2);
        run_start(16'd5, 1'b0); run_wait();
        run_start(16'd100, 1'b0); run_wait();
        chk("count_kept", 32'(count), 32'd2);

        // Borrow on the first entry aborts before the second is issued.
        clear_prog(1'b0, 3'd0, 16'h0000);
        load(OP_SUB, 16'd1); load(OP_ADD, 16'd2);
        run_start(16'd0, 1'b0); run_wait();
        repeat (2) @(negedge clk);
        chk("error_held", 32'(error), 32'd1);

        // Carry on the last entry is caught in DRAIN.
        clear_prog(1'b0, 3'd0, 16'h0000);
        load(OP_ADD, 16'd1); load(OP_ADD, 16'hFFFF);
        run_start(16'd0, 1'b0); run_wait();

        // Nine writes into an eight-entry buffer.
        clear_prog(1'b0, 3'd0, 16'h0000);
        for (int i = 0; i < 9; i++) begin
            load((i == 4) ? OP_XOR : OP_ADD, 16'(i + 1));
            if (i == 6) chk("wr_ready_7", 32'(wr_ready), 32'd1);
            if (i == 7) chk("wr_ready_full", 32'(wr_ready), 32'd0);
        end
        chk("count_full", 32'(count), 32'd8);
        run_start(16'h1000, 1'b0); run_wait();

        // Empty program: done next cycle with result = seed.
        clear_prog(1'b0, 3'd0, 16'h0000);
        chk("count_empty", 32'(count), 32'd0);
        run_start(16'h00AA, 1'b0); run_wait();

        // prog_clr with wr_en, start colliding with wr_en, writes while busy.
        clear_prog(1'b1, OP_ADD, 16'h0010);
        chk("count_clr_wr", 32'(count), 32'd1);
        run_start(16'h0005, 1'b1);
        chk("count_start_wr", 32'(count), 32'd1);
        wr_en = 1'b1; wr_opcode = OP_SUB; wr_operand = 16'h0001;
        @(negedge clk);
        wr_en = 1'b0; prog_clr = 1'b1; start = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0; start = 1'b0;
        run_wait();
        chk("count_busy_wr", 32'(count), 32'd1);

        // Reset in the middle of ISSUE.
        clear_prog(1'b0, 3'd0, 16'h0000);
        for (int i = 0; i < 4; i++) load(OP_ADD, 16'(i + 2));
        run_start(16'd1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete(); m_op.delete(); m_b.delete(); last_eidx = 3'd0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        repeat (8) @(negedge clk);
        chk("midrst_no_done", 32'(n_done - done_base), 32'd0);

        // New program after the abort.
        load(OP_SUB, 16'h0003); load(OP_AND, 16'h00F0); load(OP_XOR, 16'h000F);
        run_start(16'h00FF, 1'b0); run_wait();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
